// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared types and constants for the RTC bus arbiter.
package rtc_bus_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Parameter defaults
    localparam int NREQ_DEF    = 3;
    localparam int TIMEOUT_DEF = 255;
    localparam int GAP_DEF     = 2;

    // Values driven onto the RTC bus when nobody owns it
    localparam logic       IDLE_STROBE = 1'b1;
    localparam logic [7:0] IDLE_ADOUT  = 8'hzz;

endpackage

// File: rtl/rtc_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    logic [PW-1:0] idx;

    // Walk upward from rr_ptr modulo NREQ; the first set request wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(rr_ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter muxing NREQ requesters onto one RTC address/data bus.
// Grant ends on done from the owner or on timeout; GAP idle cycles follow.
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int GAP     = GAP_DEF      // must be >= 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       done,
    input  logic [NREQ-1:0]       ad_i,
    input  logic [NREQ-1:0]       wr_i,
    input  logic [NREQ-1:0]       rd_i,
    input  logic [NREQ-1:0]       cs_i,
    input  logic [NREQ-1:0][7:0]  adout_i,
    output logic [NREQ-1:0]       grant,
    output logic [7:0]            ADout,
    output logic                  ad,
    output logic                  wr,
    output logic                  rd,
    output logic                  cs,
    output logic                  busy,
    output logic                  tout_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nx;
    logic [7:0]      cnt, cnt_nx;          // grant timer in GRANT, gap count in GAP
    logic [NREQ-1:0] grant_nx;
    logic [PW-1:0]   rr_ptr, rr_nx;
    logic [PW-1:0]   own, own_nx;          // index of current owner, drives the mux
    logic            tout_nx;

    logic [NREQ-1:0] win;
    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic            done_hit, tmo_hit, gap_end, on_bus;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (win),
        .valid  (win_vld)
    );

    // One-hot winner to index
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (win[i]) win_idx = PW'(i);
    end

    // Only the owner's done counts; stray pulses from others mask to zero
    assign done_hit = |(done & grant);
    assign tmo_hit  = (cnt == 8'(TIMEOUT - 1));
    assign gap_end  = (cnt == 8'(GAP - 1));

    // Next-state and register updates
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant_nx = grant;
        rr_nx    = rr_ptr;
        own_nx   = own;
        tout_nx  = tout_err;
        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    state_nx = ST_GRANT;
                    grant_nx = win;
                    own_nx   = win_idx;
                    rr_nx    = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                    cnt_nx   = '0;
                end
            end
            ST_GRANT: begin
                if (done_hit) begin
                    // done wins over a coincident timeout: no error flagged
                    state_nx = ST_GAP;
                    grant_nx = '0;
                    cnt_nx   = '0;
                end else if (tmo_hit) begin
                    state_nx = ST_GAP;
                    grant_nx = '0;
                    cnt_nx   = '0;
                    tout_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
                cnt_nx   = '0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            grant    <= '0;
            rr_ptr   <= '0;
            own      <= '0;
            tout_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            grant    <= grant_nx;
            rr_ptr   <= rr_nx;
            own      <= own_nx;
            tout_err <= tout_nx;
        end
    end

    // Bus follows the owner with no added latency; idle values otherwise
    assign on_bus = (state == ST_GRANT);
    assign busy   = (state != ST_IDLE);
    assign ADout  = on_bus ? adout_i[own] : IDLE_ADOUT;
    assign ad     = on_bus ? ad_i[own]    : IDLE_STROBE;
    assign wr     = on_bus ? wr_i[own]    : IDLE_STROBE;
    assign rd     = on_bus ? rd_i[own]    : IDLE_STROBE;
    assign cs     = on_bus ? cs_i[own]    : IDLE_STROBE;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: table of single transactions plus
// hand-written rotation, timeout, stray-done and mid-grant reset sequences.
module tb_rtc_bus_arbiter;

    logic            clock = 1'b0;
    logic            reset;
    logic [2:0]      req, done, ad_i, wr_i, rd_i, cs_i;
    logic [2:0][7:0] adout_i;
    logic [2:0]      grant;
    wire  [7:0]      ADout;
    logic            ad, wr, rd, cs, busy, tout_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] zz;

    typedef struct {
        logic [2:0] req;
        int         hold;       // grant cycles after the first before done
        logic [2:0] exp_grant;
        logic [7:0] exp_ad;
    } vec_t;

    vec_t tbl [8];

    always #5 clock = ~clock;

    rtc_bus_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .done(done),
        .ad_i(ad_i), .wr_i(wr_i), .rd_i(rd_i), .cs_i(cs_i), .adout_i(adout_i),
        .grant(grant), .ADout(ADout), .ad(ad), .wr(wr), .rd(rd), .cs(cs),
        .busy(busy), .tout_err(tout_err)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_bus(input string nm);
        chk({nm, " ADout idle"}, {24'h0, ADout}, {24'h0, zz});
        chk({nm, " strobes idle"}, {28'h0, ad, wr, rd, cs}, 32'hF);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        done  = '0;
        tick(2);
        reset = 1'b0;
    endtask

    // One grant from IDLE: request, check owner and bus, done, check GAP, back to IDLE
    task automatic run_txn(input vec_t v, input int n);
        int w;
        string nm;
        w  = 0;
        nm = $sformatf("txn%0d", n);
        for (int i = 0; i < 3; i++) if (v.exp_grant[i]) w = i;
        req = v.req;
        tick();
        req = '0;
        chk({nm, " grant"}, {29'h0, grant}, {29'h0, v.exp_grant});
        chk({nm, " busy"}, {31'h0, busy}, 32'h1);
        chk({nm, " ADout"}, {24'h0, ADout}, {24'h0, v.exp_ad});
        chk({nm, " strobes"}, {28'h0, ad, wr, rd, cs},
            {28'h0, ad_i[w], wr_i[w], rd_i[w], cs_i[w]});
        tick(v.hold);
        chk({nm, " grant held"}, {29'h0, grant}, {29'h0, v.exp_grant});
        done = v.exp_grant;
        tick();
        done = '0;
        chk({nm, " gap1 grant"}, {29'h0, grant}, 32'h0);
        chk({nm, " gap1 busy"}, {31'h0, busy}, 32'h1);
        chk_idle_bus({nm, " gap1"});
        tick();
        chk({nm, " gap2 busy"}, {31'h0, busy}, 32'h1);
        tick();
        chk({nm, " idle busy"}, {31'h0, busy}, 32'h0);
        chk({nm, " idle grant"}, {29'h0, grant}, 32'h0);
    endtask

    initial begin
        logic [2:0] order [4];
        int n;

        zz = 8'hzz;
        reset = 1'b1;
        req = '0;
        done = '0;
        // requester k strobes {ad,wr,rd,cs}: r0=0011 r1=1001 r2=1100
        ad_i = 3'b110;
        wr_i = 3'b100;
        rd_i = 3'b001;
        cs_i = 3'b011;
        adout_i[0] = 8'h24;
        adout_i[1] = 8'h35;
        adout_i[2] = 8'h46;

        // rr_ptr carries across rows: 0 ->1 ->2 ->0 ->1 ->0 ->2 ->1 ->0
        tbl[0] = '{3'b001, 40, 3'b001, 8'h24};
        tbl[1] = '{3'b111,  5, 3'b010, 8'h35};
        tbl[2] = '{3'b111,  1, 3'b100, 8'h46};
        tbl[3] = '{3'b111,  2, 3'b001, 8'h24};
        tbl[4] = '{3'b101,  4, 3'b100, 8'h46};
        tbl[5] = '{3'b110,  6, 3'b010, 8'h35};
        tbl[6] = '{3'b011,  7, 3'b001, 8'h24};
        tbl[7] = '{3'b100,  3, 3'b100, 8'h46};

        tick(2);
        reset = 1'b0;
        chk("reset grant", {29'h0, grant}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset tout_err", {31'h0, tout_err}, 32'h0);
        chk_idle_bus("reset");
        tick(2);
        chk("idle no req grant", {29'h0, grant}, 32'h0);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], i);

        // Fairness with all requests held
        do_reset();
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        req = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rot%0d grant", k), {29'h0, grant}, {29'h0, order[k]});
            tick(9);
            done = order[k];
            tick();
            done = '0;
            chk($sformatf("rot%0d gap1", k), {29'h0, grant, busy}, 32'h1);
            tick();
            chk($sformatf("rot%0d gap2", k), {29'h0, grant, busy}, 32'h1);
            tick();
            chk($sformatf("rot%0d idle", k), {29'h0, grant, busy}, 32'h0);
            tick();
        end
        req = '0;

        // Stray done and req drop do not end a grant
        do_reset();
        req = 3'b001;
        tick();
        req = '0;
        done = 3'b100;
        tick();
        done = '0;
        chk("stray done grant", {29'h0, grant}, 32'h1);
        tick(3);
        chk("req drop grant", {29'h0, grant}, 32'h1);
        done = 3'b001;
        tick();
        done = '0;
        chk("owner done grant", {29'h0, grant}, 32'h0);

        // Timeout: 255 grant cycles, sticky error
        do_reset();
        req = 3'b010;
        tick();
        req = '0;
        n = 0;
        while (grant == 3'b010 && n < 300) begin
            n++;
            tick();
        end
        chk("timeout length", n, 255);
        chk("timeout tout_err", {31'h0, tout_err}, 32'h1);
        chk("timeout busy", {31'h0, busy}, 32'h1);
        tick(2);
        req = 3'b001;
        tick();
        req = '0;
        chk("after tmo grant", {29'h0, grant}, 32'h1);
        done = 3'b001;
        tick();
        done = '0;
        tick(2);
        chk("tout_err sticky", {31'h0, tout_err}, 32'h1);
        do_reset();
        chk("tout_err reset", {31'h0, tout_err}, 32'h0);

        // done and timeout in the same cycle: done wins
        req = 3'b010;
        tick();
        req = '0;
        tick(254);
        chk("pre-timeout grant", {29'h0, grant}, 32'h2);
        done = 3'b010;
        tick();
        done = '0;
        chk("done+tmo grant", {29'h0, grant}, 32'h0);
        chk("done+tmo busy", {31'h0, busy}, 32'h1);
        chk("done+tmo tout_err", {31'h0, tout_err}, 32'h0);
        tick(2);

        // Reset mid-grant
        adout_i[0] = 8'h24;
        wr_i[0]    = 1'b0;
        req = 3'b001;
        tick();
        req = 3'b110;
        tick(5);
        chk("mid ADout", {24'h0, ADout}, 32'h24);
        chk("mid wr", {31'h0, wr}, 32'h0);
        reset = 1'b1;
        tick();
        chk("rst grant", {29'h0, grant}, 32'h0);
        chk("rst wr", {31'h0, wr}, 32'h1);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk_idle_bus("rst");
        reset = 1'b0;
        req = 3'b111;
        tick();
        chk("rst rr_ptr", {29'h0, grant}, 32'h1);
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
